// File: rtl/tick_timer_bank_if.sv
// Bus bundle for tick_timer_bank: prescaler control, tick strobe and the
// per-channel start/status vectors (channel i at [i*TMR_W +: TMR_W]).
interface tick_timer_bank_if #(
  parameter int CNT_W = 25,
  parameter int NCH   = 4,
  parameter int TMR_W = 8
);
  logic                   en;
  logic                   div_load;
  logic [CNT_W-1:0]       div_value;
  logic                   tick;
  logic [NCH-1:0]         ch_start;
  logic [NCH*TMR_W-1:0]   ch_len;
  logic [NCH-1:0]         ch_busy;
  logic [NCH-1:0]         ch_done;
  logic [NCH*TMR_W-1:0]   ch_remain;

  modport master (
    output en, div_load, div_value, ch_start, ch_len,
    input  tick, ch_busy, ch_done, ch_remain
  );

  modport slave (
    input  en, div_load, div_value, ch_start, ch_len,
    output tick, ch_busy, ch_done, ch_remain
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Runtime-loadable prescaler producing a one-cycle tick, feeding NCH
// independent countdown channels that count in ticks.
module tick_timer_bank #(
  parameter int CNT_W       = 25,
  parameter int DIV_DEFAULT = 10,
  parameter int NCH         = 4,
  parameter int TMR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  tick_timer_bank_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

  logic [CNT_W-1:0]       div_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   tick_r;
  logic [CNT_W-1:0]       eff_div_s;
  logic [CNT_W-1:0]       load_div_s;
  logic                   tk_s;

  logic [NCH*TMR_W-1:0]   remain_r;
  logic [NCH-1:0]         busy_r;
  logic [NCH-1:0]         done_r;
  logic [NCH*TMR_W-1:0]   remain_nxt_s;
  logic [NCH-1:0]         busy_nxt_s;
  logic [NCH-1:0]         done_nxt_s;

  // Divisor 0 is treated as 1, both for reloads and for a freshly loaded value.
  always_comb begin
    eff_div_s  = (div_r == {CNT_W{1'b0}}) ? CNT_ONE : div_r;
    load_div_s = (bus.div_value == {CNT_W{1'b0}}) ? CNT_ONE : bus.div_value;
    tk_s       = bus.en & ~bus.div_load & (cnt_r == CNT_ONE);
  end

  // Prescaler: div_load restarts the phase; en low freezes count and phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r  <= DIV_RST;
      cnt_r  <= DIV_RST;
      tick_r <= 1'b0;
    end else if (bus.div_load) begin
      div_r  <= bus.div_value;
      cnt_r  <= load_div_s;
      tick_r <= 1'b0;
    end else if (bus.en) begin
      if (cnt_r == CNT_ONE) begin
        tick_r <= 1'b1;
        cnt_r  <= eff_div_s;
      end else begin
        tick_r <= 1'b0;
        cnt_r  <= cnt_r - CNT_ONE;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  // Channel next state; a start wins over a coincident tk on the same channel.
  always_comb begin
    remain_nxt_s = remain_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_start[i]) begin
        if (bus.ch_len[i*TMR_W +: TMR_W] != TMR_ZERO) begin
          remain_nxt_s[i*TMR_W +: TMR_W] = bus.ch_len[i*TMR_W +: TMR_W];
          busy_nxt_s[i]                  = 1'b1;
          done_nxt_s[i]                  = 1'b0;
        end else begin
          remain_nxt_s[i*TMR_W +: TMR_W] = TMR_ZERO;
          busy_nxt_s[i]                  = 1'b0;
          done_nxt_s[i]                  = 1'b1;
        end
      end else if (busy_r[i] && tk_s) begin
        remain_nxt_s[i*TMR_W +: TMR_W] = remain_r[i*TMR_W +: TMR_W] - TMR_ONE;
        if (remain_r[i*TMR_W +: TMR_W] == TMR_ONE) begin
          busy_nxt_s[i] = 1'b0;
          done_nxt_s[i] = 1'b1;
        end else begin
          busy_nxt_s[i] = 1'b1;
          done_nxt_s[i] = 1'b0;
        end
      end else begin
        remain_nxt_s[i*TMR_W +: TMR_W] = remain_r[i*TMR_W +: TMR_W];
        busy_nxt_s[i]                  = busy_r[i];
        done_nxt_s[i]                  = 1'b0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_r <= {(NCH*TMR_W){1'b0}};
      busy_r   <= {NCH{1'b0}};
      done_r   <= {NCH{1'b0}};
    end else begin
      remain_r <= remain_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign bus.tick      = tick_r;
  assign bus.ch_busy   = busy_r;
  assign bus.ch_done   = done_r;
  assign bus.ch_remain = remain_r;

endmodule

// File: tb/tb_tick_timer_bank.sv
// Directed bench for tick_timer_bank: prescaler period/reload/pause, channel
// countdown, zero-length start, restart on a tick, simultaneous done, reset.
module tb_tick_timer_bank;

  localparam int CNT_W = 25;
  localparam int NCH   = 4;
  localparam int TMR_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tick_timer_bank_if #(.CNT_W(CNT_W), .NCH(NCH), .TMR_W(TMR_W)) bus ();

  tick_timer_bank #(
    .CNT_W(CNT_W), .DIV_DEFAULT(10), .NCH(NCH), .TMR_W(TMR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled and inputs driven off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    bus.ch_start  = '0;
    bus.ch_len    = '0;
    step_n(2);
    check_val("rst_tick",   32'(bus.tick), 32'd0);
    check_val("rst_busy",   32'(bus.ch_busy), 32'd0);
    check_val("rst_done",   32'(bus.ch_done), 32'd0);
    check_val("rst_remain", 32'(bus.ch_remain), 32'd0);
    rst = 1'b0;

    // Default divisor 10: first tick on edge 10.
    for (int n = 1; n <= 13; n++) begin
      step();
      check_val($sformatf("div10_e%0d", n), 32'(bus.tick), 32'((n == 10) ? 1 : 0));
    end
    check_val("idle_busy", 32'(bus.ch_busy), 32'd0);

    // Load 3 at edge 14: ticks at 17, 20, 23.
    bus.div_load = 1'b1; bus.div_value = 25'd3;
    step();
    check_val("load3_e14", 32'(bus.tick), 32'd0);
    bus.div_load = 1'b0;
    for (int n = 15; n <= 23; n++) begin
      step();
      check_val($sformatf("div3_e%0d", n), 32'(bus.tick),
                32'((n == 17 || n == 20 || n == 23) ? 1 : 0));
    end

    // Divisor 0 behaves as 1: tick every cycle after the load cycle.
    bus.div_load = 1'b1; bus.div_value = 25'd0;
    step();
    check_val("load0", 32'(bus.tick), 32'd0);
    bus.div_load = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check_val($sformatf("div0_%0d", n), 32'(bus.tick), 32'd1);
    end

    // D=4, loaded at r0: ticks at r4, r8, r12, r16 ...
    bus.div_load = 1'b1; bus.div_value = 25'd4;
    step();
    bus.div_load = 1'b0;
    step_n(4);
    check_val("d4_r4_tick", 32'(bus.tick), 32'd1);
    bus.ch_start = 4'b0001; bus.ch_len = 32'h0000_0003;
    step();                                           // r5
    bus.ch_start = '0;
    check_val("c0_start_busy", 32'(bus.ch_busy), 32'h1);
    check_val("c0_start_rem",  32'(bus.ch_remain), 32'h3);
    step_n(3);                                        // r8
    check_val("c0_r8_rem",  32'(bus.ch_remain), 32'h2);
    step_n(4);                                        // r12
    check_val("c0_r12_rem", 32'(bus.ch_remain), 32'h1);
    check_val("c0_r12_done", 32'(bus.ch_done), 32'h0);
    step_n(4);                                        // r16
    check_val("c0_r16_tick", 32'(bus.tick), 32'd1);
    check_val("c0_r16_done", 32'(bus.ch_done), 32'h1);
    check_val("c0_r16_busy", 32'(bus.ch_busy), 32'h0);
    check_val("c0_r16_rem",  32'(bus.ch_remain), 32'h0);
    step();                                           // r17
    check_val("c0_r17_done", 32'(bus.ch_done), 32'h0);

    // Channel 1 len 2, then a 7-cycle en gap.
    bus.ch_start = 4'b0010; bus.ch_len = 32'h0000_0200;
    step();                                           // r18
    bus.ch_start = '0;
    check_val("c1_start_rem", 32'(bus.ch_remain), 32'h0000_0200);
    step_n(2);                                        // r20
    check_val("c1_r20_tick", 32'(bus.tick), 32'd1);
    check_val("c1_r20_rem",  32'(bus.ch_remain), 32'h0000_0100);
    bus.en = 1'b0;
    for (int n = 21; n <= 27; n++) begin
      step();
      check_val($sformatf("pause_tick_r%0d", n), 32'(bus.tick), 32'd0);
    end
    check_val("pause_rem",  32'(bus.ch_remain), 32'h0000_0100);
    check_val("pause_busy", 32'(bus.ch_busy), 32'h2);
    bus.en = 1'b1;
    step_n(3);                                        // r30
    check_val("resume_r30_tick", 32'(bus.tick), 32'd0);
    step();                                           // r31
    check_val("resume_r31_tick", 32'(bus.tick), 32'd1);
    check_val("c1_done", 32'(bus.ch_done), 32'h2);
    check_val("c1_busy", 32'(bus.ch_busy), 32'h0);

    // Zero-length start on channel 2.
    bus.ch_start = 4'b0100; bus.ch_len = 32'h0000_0000;
    step();                                           // r32
    bus.ch_start = '0;
    check_val("c2_zero_done", 32'(bus.ch_done), 32'h4);
    check_val("c2_zero_busy", 32'(bus.ch_busy), 32'h0);
    step();                                           // r33
    check_val("c2_zero_done_off", 32'(bus.ch_done), 32'h0);
    check_val("c2_zero_busy_off", 32'(bus.ch_busy), 32'h0);

    // Channel 0 len 2 (ticks r35, r39), restarted with 5 exactly on the r39 tick.
    bus.ch_start = 4'b0001; bus.ch_len = 32'h0000_0002;
    step();                                           // r34
    bus.ch_start = '0;
    step();                                           // r35
    check_val("c0b_r35_rem", 32'(bus.ch_remain), 32'h1);
    step_n(3);                                        // r38
    bus.ch_start = 4'b0001; bus.ch_len = 32'h0000_0005;
    step();                                           // r39
    bus.ch_start = '0;
    check_val("restart_tick", 32'(bus.tick), 32'd1);
    check_val("restart_rem",  32'(bus.ch_remain), 32'h5);
    check_val("restart_done", 32'(bus.ch_done), 32'h0);
    check_val("restart_busy", 32'(bus.ch_busy), 32'h1);

    // All four channels len 1: done together at r43.
    bus.ch_start = 4'b1111; bus.ch_len = 32'h0101_0101;
    step();                                           // r40
    bus.ch_start = '0;
    check_val("all_busy", 32'(bus.ch_busy), 32'hF);
    check_val("all_rem",  32'(bus.ch_remain), 32'h0101_0101);
    step_n(2);                                        // r42
    check_val("all_r42_done", 32'(bus.ch_done), 32'h0);
    step();                                           // r43
    check_val("all_done",     32'(bus.ch_done), 32'hF);
    check_val("all_busy_off", 32'(bus.ch_busy), 32'h0);
    check_val("all_rem_zero", 32'(bus.ch_remain), 32'h0);

    // Reset mid-count with three channels busy.
    bus.ch_start = 4'b0111; bus.ch_len = 32'h0005_0403;
    step();                                           // r44
    bus.ch_start = '0;
    check_val("pre_rst_busy", 32'(bus.ch_busy), 32'h7);
    step();                                           // r45
    rst = 1'b1;
    step();
    check_val("mid_rst_tick",   32'(bus.tick), 32'd0);
    check_val("mid_rst_busy",   32'(bus.ch_busy), 32'h0);
    check_val("mid_rst_done",   32'(bus.ch_done), 32'h0);
    check_val("mid_rst_remain", 32'(bus.ch_remain), 32'h0);
    rst = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      step();
      check_val($sformatf("post_rst_e%0d", n), 32'(bus.tick), 32'((n == 10) ? 1 : 0));
    end
    check_val("post_rst_busy", 32'(bus.ch_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
